// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// Owns the PC register and selects each cycle between:
//   - sequential increment
//   - hold on stall
//   - branch redirect from EX
//   - jump redirect from ID
// A redirect seen during a stall is parked in a one-entry pending buffer and
// applied when the stall releases.
// Optional feature macro: PC_SEQ_TRAP_EN adds a top-priority trap redirect
// (trap_valid_i, epc_o, TRAP_VECTOR).

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pc_sequencer #(
    parameter int                    PC_WIDTH    = `PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
`ifdef PC_SEQ_TRAP_EN
    parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR = PC_WIDTH'('h10),
`endif
    parameter int                    PC_STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                br_valid_i,
    input  logic [PC_WIDTH-1:0] br_target_i,
    input  logic                jmp_valid_i,
    input  logic [PC_WIDTH-1:0] jmp_target_i,
`ifdef PC_SEQ_TRAP_EN
    input  logic                trap_valid_i,
    output logic [PC_WIDTH-1:0] epc_o,
`endif
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                pc_valid_o,
    output logic                flush_if_o,
    output logic                flush_id_o,
    output logic                redirect_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        PEND = 2'd3
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_valid;
    logic [PC_WIDTH-1:0] r_pend_target;
    logic                r_pend_is_br;
`ifdef PC_SEQ_TRAP_EN
    logic [PC_WIDTH-1:0] r_epc;
`endif

    logic                w_apply_br;
    logic                w_apply_jmp;
    logic                w_trap;
    logic [PC_WIDTH-1:0] w_target;

    // Decide which redirect (if any) is applied this cycle and its target.
    // BOOT and reset suppress everything; during PEND a live branch beats the
    // parked entry, which in turn beats a live jump.
    always_comb begin
        w_apply_br  = 1'b0;
        w_apply_jmp = 1'b0;
        w_trap      = 1'b0;
        w_target    = r_pc;
        if (!rst) begin
            case (r_state)
                RUN, HOLD: begin
                    if (!stall_i) begin
                        if (br_valid_i) begin
                            w_apply_br = 1'b1;
                            w_target   = br_target_i;
                        end else if (jmp_valid_i) begin
                            w_apply_jmp = 1'b1;
                            w_target    = jmp_target_i;
                        end
                    end
                end
                PEND: begin
                    if (!stall_i) begin
                        if (br_valid_i) begin
                            w_apply_br = 1'b1;
                            w_target   = br_target_i;
                        end else if (r_pend_is_br) begin
                            w_apply_br = 1'b1;
                            w_target   = r_pend_target;
                        end else begin
                            w_apply_jmp = 1'b1;
                            w_target    = r_pend_target;
                        end
                    end
                end
                default: ;
            endcase
`ifdef PC_SEQ_TRAP_EN
            // Trap ignores stall and overrides any branch/jump choice.
            if (trap_valid_i && r_state != BOOT) begin
                w_trap      = 1'b1;
                w_apply_br  = 1'b0;
                w_apply_jmp = 1'b0;
                w_target    = TRAP_VECTOR;
            end
`endif
        end
    end

    assign flush_if_o = w_apply_br | w_apply_jmp | w_trap;
    assign flush_id_o = w_apply_br | w_trap;
    assign redirect_o = w_apply_br | w_apply_jmp | w_trap;

    // State machine: PC register, valid qualifier and pending redirect buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_pend_target <= '0;
            r_pend_is_br  <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
            r_epc         <= '0;
`endif
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN, HOLD: begin
                    if (stall_i) begin
                        if (br_valid_i) begin
                            r_pend_target <= br_target_i;
                            r_pend_is_br  <= 1'b1;
                            r_state       <= PEND;
                        end else if (jmp_valid_i) begin
                            r_pend_target <= jmp_target_i;
                            r_pend_is_br  <= 1'b0;
                            r_state       <= PEND;
                        end else begin
                            r_state <= HOLD;
                        end
                    end else begin
                        if (w_apply_br || w_apply_jmp) begin
                            r_pc <= w_target;
                        end else begin
                            r_pc <= r_pc + PC_WIDTH'(PC_STEP);
                        end
                        r_state <= RUN;
                    end
                end
                PEND: begin
                    if (stall_i) begin
                        // A younger jump must not displace an older branch.
                        if (br_valid_i) begin
                            r_pend_target <= br_target_i;
                            r_pend_is_br  <= 1'b1;
                        end else if (jmp_valid_i && !r_pend_is_br) begin
                            r_pend_target <= jmp_target_i;
                        end
                    end else begin
                        r_pc          <= w_target;
                        r_pend_target <= '0;
                        r_pend_is_br  <= 1'b0;
                        r_state       <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
`ifdef PC_SEQ_TRAP_EN
            if (w_trap) begin
                r_epc         <= r_pc;
                r_pc          <= TRAP_VECTOR;
                r_pend_target <= '0;
                r_pend_is_br  <= 1'b0;
                r_state       <= RUN;
            end
`endif
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_pc_valid;
`ifdef PC_SEQ_TRAP_EN
    assign epc_o      = r_epc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: one step per clock, expected
// observations pushed to a scoreboard queue as each step is driven and
// popped for comparison mid-cycle.
module tb_pc_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_i;
    logic         br_valid_i;
    logic [W-1:0] br_target_i;
    logic         jmp_valid_i;
    logic [W-1:0] jmp_target_i;
    logic [W-1:0] pc_o;
    logic         pc_valid_o;
    logic         flush_if_o;
    logic         flush_id_o;
    logic         redirect_o;
`ifdef PC_SEQ_TRAP_EN
    logic         trap_valid_i = 1'b0;
    logic [W-1:0] epc_o;
`endif

    pc_sequencer #(
        .PC_WIDTH (W),
        .RESET_PC ('0),
        .PC_STEP  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_valid_i   (br_valid_i),
        .br_target_i  (br_target_i),
        .jmp_valid_i  (jmp_valid_i),
        .jmp_target_i (jmp_target_i),
`ifdef PC_SEQ_TRAP_EN
        .trap_valid_i (trap_valid_i),
        .epc_o        (epc_o),
`endif
        .pc_o         (pc_o),
        .pc_valid_o   (pc_valid_o),
        .flush_if_o   (flush_if_o),
        .flush_id_o   (flush_id_o),
        .redirect_o   (redirect_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] pc;
        logic         valid;
        logic         fif;
        logic         fid;
        logic         red;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Drive one cycle of stimulus, record the expected observation, then
    // compare mid-cycle and advance to just after the next rising edge.
    task automatic step(input string tag, input logic r, input logic st,
                        input logic bv, input logic [W-1:0] bt,
                        input logic jv, input logic [W-1:0] jt,
                        input logic [W-1:0] e_pc, input logic e_v,
                        input logic e_fif, input logic e_fid, input logic e_red);
        exp_t e;
        exp_t got;
        rst          = r;
        stall_i      = st;
        br_valid_i   = bv;
        br_target_i  = bt;
        jmp_valid_i  = jv;
        jmp_target_i = jt;
        e.tag = tag; e.pc = e_pc; e.valid = e_v; e.fif = e_fif; e.fid = e_fid; e.red = e_red;
        sb_q.push_back(e);
        @(negedge clk);
        n_vec++;
        assert (sb_q.size() == 1) else begin
            n_fail++;
            $error("FAIL %s scoreboard observed=%0d expected=1", tag, sb_q.size());
        end
        got = sb_q.pop_front();
        n_vec++;
        assert (pc_o === got.pc) else begin
            n_fail++;
            $error("FAIL %s pc_o observed=%h expected=%h", got.tag, pc_o, got.pc);
        end
        n_vec++;
        assert (pc_valid_o === got.valid) else begin
            n_fail++;
            $error("FAIL %s pc_valid_o observed=%b expected=%b", got.tag, pc_valid_o, got.valid);
        end
        n_vec++;
        assert (flush_if_o === got.fif) else begin
            n_fail++;
            $error("FAIL %s flush_if_o observed=%b expected=%b", got.tag, flush_if_o, got.fif);
        end
        n_vec++;
        assert (flush_id_o === got.fid) else begin
            n_fail++;
            $error("FAIL %s flush_id_o observed=%b expected=%b", got.tag, flush_id_o, got.fid);
        end
        n_vec++;
        assert (redirect_o === got.red) else begin
            n_fail++;
            $error("FAIL %s redirect_o observed=%b expected=%b", got.tag, redirect_o, got.red);
        end
        $display("step %-10s pc=%h valid=%b fif=%b fid=%b red=%b", tag, pc_o, pc_valid_o,
                 flush_if_o, flush_id_o, redirect_o);
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] ONES = '1;

    initial begin
        rst = 1'b1; stall_i = 1'b0; br_valid_i = 1'b0; br_target_i = '0;
        jmp_valid_i = 1'b0; jmp_target_i = '0;
        @(posedge clk);
        #1;
        //    tag          rst st  bv bt     jv jt     pc     v  fif fid red
        // Reset held three cycles, then the BOOT cycle, then counting.
        step("rst0",      1, 0, 0, 0,     0, 0,     0,     0, 0, 0, 0);
        step("rst1",      1, 0, 1, 'h11,  1, 'h22,  0,     0, 0, 0, 0);
        step("rst2",      1, 0, 0, 0,     0, 0,     0,     0, 0, 0, 0);
        step("boot",      0, 0, 0, 0,     0, 0,     0,     0, 0, 0, 0);
        step("seq0",      0, 0, 0, 0,     0, 0,     0,     1, 0, 0, 0);
        step("seq1",      0, 0, 0, 0,     0, 0,     1,     1, 0, 0, 0);
        step("seq2",      0, 0, 0, 0,     0, 0,     2,     1, 0, 0, 0);
        step("seq3",      0, 0, 0, 0,     0, 0,     3,     1, 0, 0, 0);
        step("seq4",      0, 0, 0, 0,     0, 0,     4,     1, 0, 0, 0);
        // Branch and jump together at pc=5: branch wins.
        step("brjmp",     0, 0, 1, 'h40,  1, 'h80,  5,     1, 1, 1, 1);
        step("at40",      0, 0, 0, 0,     1, 6,     'h40,  1, 1, 0, 1);
        step("seq6",      0, 0, 0, 0,     0, 0,     6,     1, 0, 0, 0);
        // Jump alone at pc=7.
        step("jmp7",      0, 0, 0, 0,     1, 'h20,  7,     1, 1, 0, 1);
        step("at20",      0, 0, 0, 0,     0, 0,     'h20,  1, 0, 0, 0);
        step("at21",      0, 0, 0, 0,     1, 8,     'h21,  1, 1, 0, 1);
        step("seq8",      0, 0, 0, 0,     0, 0,     8,     1, 0, 0, 0);
        // Stall at pc=9: branch parked, later jump must not displace it.
        step("stl_br",    0, 1, 1, 'h30,  0, 0,     9,     1, 0, 0, 0);
        step("stl_jmp",   0, 1, 0, 0,     1, 'h50,  9,     1, 0, 0, 0);
        step("stl_hold",  0, 1, 0, 0,     0, 0,     9,     1, 0, 0, 0);
        step("release",   0, 0, 0, 0,     0, 0,     9,     1, 1, 1, 1);
        // Plain stall (no redirect) then jump to all-ones on release.
        step("at30_stl",  0, 1, 0, 0,     0, 0,     'h30,  1, 0, 0, 0);
        step("hold_jmp",  0, 0, 0, 0,     1, ONES,  'h30,  1, 1, 0, 1);
        step("ones",      0, 0, 0, 0,     0, 0,     ONES,  1, 0, 0, 0);
        // Wrapped to 0; park a jump, replace it with a newer jump, and a
        // live jump on release loses to the parked one.
        step("wrap0",     0, 1, 0, 0,     1, 'h70,  0,     1, 0, 0, 0);
        step("pjmp_ovr",  0, 1, 0, 0,     1, 'h74,  0,     1, 0, 0, 0);
        step("pjmp_app",  0, 0, 0, 0,     1, 'h90,  0,     1, 1, 0, 1);
        // Park a branch, then reset while pending.
        step("at74_br",   0, 1, 1, 'h60,  0, 0,     'h74,  1, 0, 0, 0);
        step("rst_pend",  1, 1, 0, 0,     0, 0,     'h74,  1, 0, 0, 0);
        step("boot2",     0, 0, 1, 'h99,  0, 0,     0,     0, 0, 0, 0);
        step("post0",     0, 0, 0, 0,     0, 0,     0,     1, 0, 0, 0);
        step("post1",     0, 0, 0, 0,     0, 0,     1,     1, 0, 0, 0);
        step("post2",     0, 0, 0, 0,     0, 0,     2,     1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
